// File: rtl/multicycle_control.sv
// multicycle_control: RV32I multi-cycle sequencer FSM driving a shared ALU and one unified memory port
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] i_op_code,
  input  logic [2:0] i_func3,
  input  logic [6:0] i_func7,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_write,
  output logic       o_adr_src,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_reg_write,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_result_src,
  output logic [2:0] o_imm_type,
  output logic [2:0] o_alu_control,
  output logic       o_instr_done,
  output logic       o_illegal
);
  typedef enum logic [3:0] {FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BEQ, JAL} state_t;
  state_t r_state, w_next;
  logic w_is_sw;
  logic [2:0] w_alu_fn;
  logic w_unused;
  assign w_unused = ^{i_func7[6], i_func7[4:0]};
  assign w_is_sw = i_op_code == 7'b0100011;
  assign w_alu_fn = (i_func3 == 3'b111) ? 3'b010 :
                    (i_func3 == 3'b110) ? 3'b011 :
                    (i_func3 == 3'b010) ? 3'b101 :
                    (i_func3 == 3'b000 && r_state == EXEC_R && i_func7[5]) ? 3'b001 : 3'b000;
  always_ff @(posedge clk)
    r_state <= rst ? FETCH : w_next;
  always_comb begin
    w_next = r_state;
    o_mem_req = 1'b0;
    o_mem_write = 1'b0;
    o_adr_src = 1'b0;
    o_ir_write = 1'b0;
    o_pc_write = 1'b0;
    o_reg_write = 1'b0;
    o_alu_src_a = 2'b00;
    o_alu_src_b = 2'b00;
    o_result_src = 2'b00;
    o_imm_type = 3'b000;
    o_alu_control = 3'b000;
    o_instr_done = 1'b0;
    o_illegal = 1'b0;
    if (!rst) begin
      case (r_state)
        FETCH: begin
          o_mem_req = 1'b1;
          o_alu_src_b = 2'b10;
          o_result_src = 2'b10;
          o_ir_write = i_mem_ready;
          o_pc_write = i_mem_ready;
          w_next = i_mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          o_alu_src_a = 2'b01;
          o_alu_src_b = 2'b01;
          o_imm_type = 3'b010;
          w_next = (i_op_code == 7'b0000011 || w_is_sw) ? MEMADR :
                   (i_op_code == 7'b0110011) ? EXEC_R :
                   (i_op_code == 7'b0010011) ? EXEC_I :
                   (i_op_code == 7'b1100011) ? BEQ :
                   (i_op_code == 7'b1101111) ? JAL : FETCH;
          o_illegal = w_next == FETCH;
          o_instr_done = w_next == FETCH;
        end
        MEMADR: begin
          o_alu_src_a = 2'b10;
          o_alu_src_b = 2'b01;
          o_imm_type = w_is_sw ? 3'b001 : 3'b000;
          w_next = w_is_sw ? MEMWR : MEMRD;
        end
        MEMRD: begin
          o_mem_req = 1'b1;
          o_adr_src = 1'b1;
          w_next = i_mem_ready ? MEMWB : MEMRD;
        end
        MEMWB: begin
          o_result_src = 2'b01;
          o_reg_write = 1'b1;
          o_instr_done = 1'b1;
          w_next = FETCH;
        end
        MEMWR: begin
          o_mem_req = 1'b1;
          o_mem_write = 1'b1;
          o_adr_src = 1'b1;
          o_instr_done = i_mem_ready;
          w_next = i_mem_ready ? FETCH : MEMWR;
        end
        EXEC_R, EXEC_I: begin
          o_alu_src_a = 2'b10;
          o_alu_src_b = (r_state == EXEC_I) ? 2'b01 : 2'b00;
          o_alu_control = w_alu_fn;
          w_next = ALUWB;
        end
        ALUWB: begin
          o_reg_write = 1'b1;
          o_instr_done = 1'b1;
          w_next = FETCH;
        end
        BEQ: begin
          o_alu_src_a = 2'b10;
          o_alu_control = 3'b001;
          o_pc_write = i_zero;
          o_instr_done = 1'b1;
          w_next = FETCH;
        end
        JAL: begin
          o_alu_src_a = 2'b01;
          o_alu_src_b = 2'b10;
          o_pc_write = 1'b1;
          w_next = ALUWB;
        end
        default: w_next = FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed table, corner sequences and randomized instructions vs an expected per-cycle control script
module tb_multicycle_control;
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] i_op_code = '0, i_func7 = '0;
  logic [2:0] i_func3 = '0;
  logic i_zero = 1'b0, i_mem_ready = 1'b1;
  logic o_mem_req, o_mem_write, o_adr_src, o_ir_write, o_pc_write, o_reg_write, o_instr_done, o_illegal;
  logic [1:0] o_alu_src_a, o_alu_src_b, o_result_src;
  logic [2:0] o_imm_type, o_alu_control;
  int tests = 0, fails = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .i_op_code(i_op_code), .i_func3(i_func3), .i_func7(i_func7),
    .i_zero(i_zero), .i_mem_ready(i_mem_ready), .o_mem_req(o_mem_req), .o_mem_write(o_mem_write),
    .o_adr_src(o_adr_src), .o_ir_write(o_ir_write), .o_pc_write(o_pc_write), .o_reg_write(o_reg_write),
    .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b), .o_result_src(o_result_src),
    .o_imm_type(o_imm_type), .o_alu_control(o_alu_control), .o_instr_done(o_instr_done), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  typedef struct {logic rdy; logic [19:0] exp;} step_t;
  typedef struct {string name; logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic z; int wf; int wm; int cyc;} vec_t;
  step_t q[$];
  vec_t tbl[14];

  function automatic logic [19:0] o(input int req, wr, adr, irw, pcw, rw, a, b, rs, imm, alu, done, ill);
    return {req[0], wr[0], adr[0], irw[0], pcw[0], rw[0], a[1:0], b[1:0], rs[1:0], imm[2:0], alu[2:0], done[0], ill[0]};
  endfunction

  function automatic logic [19:0] got();
    return {o_mem_req, o_mem_write, o_adr_src, o_ir_write, o_pc_write, o_reg_write, o_alu_src_a, o_alu_src_b,
            o_result_src, o_imm_type, o_alu_control, o_instr_done, o_illegal};
  endfunction

  function automatic int alu_exp(input bit is_r, input logic [2:0] f3, input logic [6:0] f7);
    case (f3)
      3'b000: return (is_r && f7[5]) ? 1 : 0;
      3'b111: return 2;
      3'b110: return 3;
      3'b010: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic logic idle(input bit rnd);
    return rnd && ($urandom_range(0, 1) == 1);
  endfunction

  task automatic check(input string nm, input int k, input logic [19:0] g, input logic [19:0] e);
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s step%0d got=%h exp=%h", nm, k, g, e);
    end
  endtask

  // Expected cycle-by-cycle script for one instruction; each step also carries the mem_ready to drive.
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic z,
                       input int wf, input int wm, input bit rnd);
    int legal, sw, isr;
    q.delete();
    legal = (op inside {LW, SW, RT, IT, BQ, JL}) ? 1 : 0;
    sw = (op == SW) ? 1 : 0;
    isr = (op == RT) ? 1 : 0;
    for (int i = 0; i < wf; i++) q.push_back('{1'b0, o(1,0,0,0,0,0,0,2,2,0,0,0,0)});
    q.push_back('{1'b1, o(1,0,0,1,1,0,0,2,2,0,0,0,0)});
    q.push_back('{idle(rnd), o(0,0,0,0,0,0,1,1,0,2,0,1-legal,1-legal)});
    if (op == LW || op == SW) begin
      q.push_back('{idle(rnd), o(0,0,0,0,0,0,2,1,0,sw,0,0,0)});
      for (int i = 0; i < wm; i++) q.push_back('{1'b0, o(1,sw,1,0,0,0,0,0,0,0,0,0,0)});
      q.push_back('{1'b1, o(1,sw,1,0,0,0,0,0,0,0,0,sw,0)});
      if (sw == 0) q.push_back('{idle(rnd), o(0,0,0,0,0,1,0,0,1,0,0,1,0)});
    end else if (op == RT || op == IT) begin
      q.push_back('{idle(rnd), o(0,0,0,0,0,0,2,1-isr,0,0,alu_exp(isr == 1, f3, f7),0,0)});
      q.push_back('{idle(rnd), o(0,0,0,0,0,1,0,0,0,0,0,1,0)});
    end else if (op == BQ) begin
      q.push_back('{idle(rnd), o(0,0,0,0,int'(z),0,2,0,0,0,1,1,0)});
    end else if (op == JL) begin
      q.push_back('{idle(rnd), o(0,0,0,0,1,0,1,2,0,0,0,0,0)});
      q.push_back('{idle(rnd), o(0,0,0,0,0,1,0,0,0,0,0,1,0)});
    end
  endtask

  task automatic run(input string nm, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic z,
                     input int wf, input int wm, input bit rnd, input int lim, output int done_at);
    build(op, f3, f7, z, wf, wm, rnd);
    done_at = 0;
    i_op_code = op; i_func3 = f3; i_func7 = f7; i_zero = z;
    for (int k = 0; k < q.size() && k < lim; k++) begin
      i_mem_ready = q[k].rdy;
      @(negedge clk);
      check(nm, k, got(), q[k].exp);
      if (o_instr_done && done_at == 0) done_at = k + 1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int d;
    tbl[0]  = '{"add",   RT, 3'b000, 7'h00, 1'b0, 0, 0, 4};
    tbl[1]  = '{"sub",   RT, 3'b000, 7'h20, 1'b0, 0, 0, 4};
    tbl[2]  = '{"and",   RT, 3'b111, 7'h00, 1'b0, 0, 0, 4};
    tbl[3]  = '{"xor",   RT, 3'b100, 7'h00, 1'b0, 0, 0, 4};
    tbl[4]  = '{"ori",   IT, 3'b110, 7'h00, 1'b0, 0, 0, 4};
    tbl[5]  = '{"slti",  IT, 3'b010, 7'h00, 1'b0, 0, 0, 4};
    tbl[6]  = '{"addi7", IT, 3'b000, 7'h20, 1'b0, 0, 0, 4};
    tbl[7]  = '{"lw2",   LW, 3'b010, 7'h00, 1'b0, 0, 2, 7};
    tbl[8]  = '{"sw",    SW, 3'b010, 7'h00, 1'b0, 0, 0, 4};
    tbl[9]  = '{"beq1",  BQ, 3'b000, 7'h00, 1'b1, 0, 0, 3};
    tbl[10] = '{"beq0",  BQ, 3'b000, 7'h00, 1'b0, 0, 0, 3};
    tbl[11] = '{"jal",   JL, 3'b000, 7'h00, 1'b0, 0, 0, 4};
    tbl[12] = '{"illeg", 7'b1111111, 3'b000, 7'h00, 1'b0, 0, 0, 2};
    tbl[13] = '{"lwf1",  LW, 3'b010, 7'h00, 1'b0, 1, 0, 6};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_zero", i, got(), 20'h0);
      @(posedge clk);
    end
    #1 rst = 1'b0; i_mem_ready = 1'b0;
    @(negedge clk);
    check("post_rst_fetch", 0, got(), o(1,0,0,0,0,0,0,2,2,0,0,0,0));
    @(posedge clk); #1;
    foreach (tbl[i]) begin
      run(tbl[i].name, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].wf, tbl[i].wm, 1'b0, 1000, d);
      tests++;
      if (d != tbl[i].cyc) begin
        fails++;
        $display("FAIL %s_cycles got=%0d exp=%0d", tbl[i].name, d, tbl[i].cyc);
      end
    end
    // Reset arriving while a load is stalled in MEMRD must drop the request immediately.
    run("lw_rst", LW, 3'b010, 7'h00, 1'b0, 0, 5, 1'b0, 5, d);
    rst = 1'b1; i_mem_ready = 1'b0;
    @(negedge clk);
    check("rst_memrd", 0, got(), 20'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_memrd_fetch", 0, got(), o(1,0,0,0,0,0,0,2,2,0,0,0,0));
    @(posedge clk); #1;
    for (int n = 0; n < 60; n++) begin
      logic [6:0] op, f7;
      int sel;
      sel = $urandom_range(0, 7);
      op = (sel == 0) ? LW : (sel == 1) ? SW : (sel == 2) ? IT : (sel == 3) ? BQ : (sel == 4) ? JL :
           (sel == 5) ? 7'b1110011 : RT;
      f7 = ($urandom_range(0, 2) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00);
      run("rand", op, 3'($urandom), f7, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, 1000, d);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
